clint_gen2: RTL and testbench



---
 rtl/clint_pkg.sv | 24 ++
 rtl/clint_tickgen.sv | 33 +++
 rtl/clint_gen2.sv | 110 +++++++++++
 tb/tb_clint_gen2.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared register-map constants and helpers for the second-generation CLINT.
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI      = 16'hBFFC;

    localparam logic [63:0] CLINT_MTIMECMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

    // Byte lanes with a clear strobe keep their old contents.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/clint_tickgen.sv
// mtime timebase: free-running prescaler or a pass-through external tick.
module clint_tickgen #(
    parameter int TICK_DIV     = 1,
    parameter int TIMEBASE_EXT = 0
) (
    input  logic CLK,
    input  logic RST_X,
    input  logic tick_ext,
    output logic tick
);

    generate
        if (TIMEBASE_EXT != 0) begin : g_ext
            logic unused_clk_rst;
            assign unused_clk_rst = CLK ^ RST_X;
            assign tick           = tick_ext;
        end else begin : g_int
            localparam logic [15:0] LAST = 16'(TICK_DIV - 1);
            logic [15:0] count;
            logic        unused_ext;

            assign unused_ext = tick_ext;
            assign tick       = (count == LAST);

            always_ff @(posedge CLK) begin
                if (!RST_X)    count <= '0;
                else if (tick) count <= '0;
                else           count <= count + 16'd1;
            end
        end
    endgenerate

endmodule

// File: rtl/clint_gen2.sv
// Core-local interruptor: per-hart msip/mtimecmp, shared 64-bit mtime with a
// low-read shadow for tear-free high reads, registered interrupt outputs.
module clint_gen2
    import clint_pkg::*;
#(
    parameter int N_HARTS      = 1,
    parameter int TICK_DIV     = 1,
    parameter int TIMEBASE_EXT = 0
) (
    input  logic               CLK,
    input  logic               RST_X,
    input  logic               w_req,
    input  logic               w_we,
    input  logic [15:0]        w_offset,
    input  logic [31:0]        w_wdata,
    input  logic [3:0]         w_wstrb,
    input  logic               w_tick_ext,
    output logic               w_rvalid,
    output logic [31:0]        w_rdata,
    output logic [N_HARTS-1:0] w_mtip,
    output logic [N_HARTS-1:0] w_msip
);

    logic [63:0]        mtime;
    logic [63:0]        mtimecmp [N_HARTS];
    logic [N_HARTS-1:0] msip;
    logic [31:0]        shadow;
    logic               tick;

    logic               wr_en;
    logic               rd_en;
    logic               mtime_lo_sel;
    logic               mtime_hi_sel;
    logic [N_HARTS-1:0] msip_sel;
    logic [N_HARTS-1:0] cmp_lo_sel;
    logic [N_HARTS-1:0] cmp_hi_sel;
    logic [31:0]        rd_data;

    clint_tickgen #(
        .TICK_DIV     (TICK_DIV),
        .TIMEBASE_EXT (TIMEBASE_EXT)
    ) u_tickgen (
        .CLK      (CLK),
        .RST_X    (RST_X),
        .tick_ext (w_tick_ext),
        .tick     (tick)
    );

    assign wr_en        = w_req & w_we;
    assign rd_en        = w_req & ~w_we;
    assign mtime_lo_sel = (w_offset == CLINT_MTIME_LO);
    assign mtime_hi_sel = (w_offset == CLINT_MTIME_HI);

    // Exact-match decode: misaligned offsets and absent harts select nothing and read 0.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        msip_sel   = '0;
        cmp_lo_sel = '0;
        cmp_hi_sel = '0;
        rd_data    = '0;
        for (int i = 0; i < N_HARTS; i++) begin
            msip_sel[i]   = (w_offset == CLINT_MSIP_BASE + 16'(4 * i));
            cmp_lo_sel[i] = (w_offset == CLINT_MTIMECMP_BASE + 16'(8 * i));
            cmp_hi_sel[i] = (w_offset == CLINT_MTIMECMP_BASE + 16'(8 * i + 4));
            if (msip_sel[i])   rd_data = {31'd0, msip[i]};
            if (cmp_lo_sel[i]) rd_data = mtimecmp[i][31:0];
            if (cmp_hi_sel[i]) rd_data = mtimecmp[i][63:32];
        end
        if (mtime_lo_sel) rd_data = mtime[31:0];
        if (mtime_hi_sel) rd_data = shadow;
    end

    // NOTE: all state below uses <= so every register samples pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            mtime    <= '0;
            msip     <= '0;
            shadow   <= '0;
            w_rvalid <= 1'b0;
            w_rdata  <= '0;
            w_mtip   <= '0;
            w_msip   <= '0;
            // NOTE: mtimecmp is a few flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < N_HARTS; i++) mtimecmp[i] <= CLINT_MTIMECMP_RST;
        end else begin
            w_rvalid <= rd_en;
            if (rd_en) w_rdata <= rd_data;
            if (rd_en && mtime_lo_sel) shadow <= mtime[63:32];

            // A bus write to either half wins over the tick for that cycle.
            if (wr_en && mtime_lo_sel)
                mtime <= {mtime[63:32], strb_merge(mtime[31:0], w_wdata, w_wstrb)};
            else if (wr_en && mtime_hi_sel)
                mtime <= {strb_merge(mtime[63:32], w_wdata, w_wstrb), mtime[31:0]};
            else if (tick)
                mtime <= mtime + 64'd1;

            for (int i = 0; i < N_HARTS; i++) begin
                if (wr_en && msip_sel[i] && w_wstrb[0]) msip[i] <= w_wdata[0];
                if (wr_en && cmp_lo_sel[i])
                    mtimecmp[i][31:0]  <= strb_merge(mtimecmp[i][31:0], w_wdata, w_wstrb);
                if (wr_en && cmp_hi_sel[i])
                    mtimecmp[i][63:32] <= strb_merge(mtimecmp[i][63:32], w_wdata, w_wstrb);
                w_mtip[i] <= (mtime >= mtimecmp[i]);
            end
            w_msip <= msip;
        end
    end

endmodule

// File: tb/tb_clint_gen2.sv
// Directed bench for clint_gen2: three instances (2 harts/div 1, div 4, external tick)
// share one bus; read responses are scored against a queue of expected results.
module tb_clint_gen2;
    import clint_pkg::*;

    typedef struct {
        int          sel;
        logic [31:0] data;
        int          cyc;
        string       tag;
    } rd_exp_t;

    logic        CLK;
    logic        RST_X;
    logic        w_req;
    logic        w_we;
    logic [15:0] w_offset;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_tick_ext;

    logic        rvalid_a, rvalid_b, rvalid_c;
    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic [1:0]  mtip_a, msip_a;
    logic [0:0]  mtip_b, msip_b, mtip_c, msip_c;

    logic        rv [3];
    logic [31:0] rdat [3];

    int          cyc = 0;
    int          n_asserts = 0;
    int          n_fail = 0;
    rd_exp_t     exp_q [$];

    int          rel, x, y, h, l;

    clint_gen2 #(.N_HARTS(2), .TICK_DIV(1), .TIMEBASE_EXT(0)) dut_a (
        .CLK(CLK), .RST_X(RST_X), .w_req(w_req), .w_we(w_we), .w_offset(w_offset),
        .w_wdata(w_wdata), .w_wstrb(w_wstrb), .w_tick_ext(w_tick_ext),
        .w_rvalid(rvalid_a), .w_rdata(rdata_a), .w_mtip(mtip_a), .w_msip(msip_a)
    );

    clint_gen2 #(.N_HARTS(1), .TICK_DIV(4), .TIMEBASE_EXT(0)) dut_b (
        .CLK(CLK), .RST_X(RST_X), .w_req(w_req), .w_we(w_we), .w_offset(w_offset),
        .w_wdata(w_wdata), .w_wstrb(w_wstrb), .w_tick_ext(w_tick_ext),
        .w_rvalid(rvalid_b), .w_rdata(rdata_b), .w_mtip(mtip_b), .w_msip(msip_b)
    );

    clint_gen2 #(.N_HARTS(1), .TICK_DIV(1), .TIMEBASE_EXT(1)) dut_c (
        .CLK(CLK), .RST_X(RST_X), .w_req(w_req), .w_we(w_we), .w_offset(w_offset),
        .w_wdata(w_wdata), .w_wstrb(w_wstrb), .w_tick_ext(w_tick_ext),
        .w_rvalid(rvalid_c), .w_rdata(rdata_c), .w_mtip(mtip_c), .w_msip(msip_c)
    );

    assign rv[0]   = rvalid_a;
    assign rv[1]   = rvalid_b;
    assign rv[2]   = rvalid_c;
    assign rdat[0] = rdata_a;
    assign rdat[1] = rdata_b;
    assign rdat[2] = rdata_c;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Each read is due exactly one cycle after it is sampled; anything else is a failure.
    always @(negedge CLK) begin : scoreboard
        rd_exp_t e;
        if (exp_q.size() != 0 && cyc >= exp_q[0].cyc) begin
            e = exp_q.pop_front();
            check({e.tag, "_rvalid"}, 64'(rv[e.sel]), 64'd1);
            check({e.tag, "_rdata"}, 64'(rdat[e.sel]), 64'(e.data));
        end else if (rv[0] | rv[1] | rv[2]) begin
            check("unexpected_rvalid", 64'(rv[0] | rv[1] | rv[2]), 64'd0);
        end
    end

    task automatic bus_write(input logic [15:0] off, input logic [31:0] data, input logic [3:0] strb);
        w_req    = 1'b1;
        w_we     = 1'b1;
        w_offset = off;
        w_wdata  = data;
        w_wstrb  = strb;
        @(negedge CLK);
        w_req    = 1'b0;
        w_we     = 1'b0;
    endtask

    task automatic bus_read(input int sel, input logic [15:0] off, input logic [31:0] expv, input string tag);
        rd_exp_t e;
        e.sel  = sel;
        e.data = expv;
        e.cyc  = cyc + 1;
        e.tag  = tag;
        exp_q.push_back(e);
        w_req    = 1'b1;
        w_we     = 1'b0;
        w_offset = off;
        w_wstrb  = 4'h0;
        @(negedge CLK);
        w_req    = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    initial begin
        // Reset with a read pending: it must be dropped, no w_rvalid afterwards.
        RST_X      = 1'b0;
        w_req      = 1'b1;
        w_we       = 1'b0;
        w_offset   = CLINT_MTIMECMP_BASE;
        w_wdata    = '0;
        w_wstrb    = '0;
        w_tick_ext = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_X = 1'b1;
        w_req = 1'b0;
        rel   = cyc;

        check("reset_mtip", 64'(mtip_a), 64'd0);
        check("reset_msip", 64'(msip_a), 64'd0);
        check("reset_rvalid", 64'(rvalid_a), 64'd0);
        check("reset_rdata", 64'(rdata_a), 64'd0);
        bus_read(0, 16'h4000, 32'hFFFF_FFFF, "rst_cmp0_lo");
        bus_read(0, 16'h4004, 32'hFFFF_FFFF, "rst_cmp0_hi");

        // External timebase: three pulses.
        repeat (3) begin
            w_tick_ext = 1'b1;
            @(negedge CLK);
            w_tick_ext = 1'b0;
            @(negedge CLK);
        end
        bus_read(2, CLINT_MTIME_LO, 32'd3, "ext_mtime");

        // Prescaler /4: after k post-reset edges mtime = k/4.
        wait_cyc(rel + 40);
        bus_read(1, CLINT_MTIME_LO, 32'd10, "presc_k40");
        wait_cyc(rel + 43);
        bus_read(1, CLINT_MTIME_LO, 32'd10, "presc_k43");
        bus_read(1, CLINT_MTIME_LO, 32'd11, "presc_k44");

        // Timer interrupt on hart 1.
        bus_write(CLINT_MTIME_HI, 32'h0, 4'hF);
        bus_write(CLINT_MTIME_LO, 32'h0, 4'hF);
        x = cyc;
        bus_write(16'h4008, 32'h20, 4'hF);
        bus_write(16'h400C, 32'h0, 4'hF);
        bus_read(0, 16'h4008, 32'h20, "cmp1_lo");
        bus_read(0, 16'h400C, 32'h0, "cmp1_hi");
        wait_cyc(x + 32);
        check("mtip_before", 64'(mtip_a), 64'b00);
        @(negedge CLK);
        check("mtip_rise", 64'(mtip_a), 64'b10);
        bus_read(0, CLINT_MTIME_LO, 32'h21, "mtime_run");
        bus_write(16'h400C, 32'h1, 4'hF);
        y = cyc;
        check("mtip_hold", 64'(mtip_a), 64'b10);
        @(negedge CLK);
        check("mtip_fall", 64'(mtip_a), 64'b00);

        // Tear-free high read across a low-word wrap.
        bus_write(CLINT_MTIME_HI, 32'h0, 4'hF);
        bus_write(CLINT_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
        h = cyc;
        bus_read(0, CLINT_MTIME_LO, 32'hFFFF_FFFE, "tf_lo");
        bus_read(0, CLINT_MTIME_HI, 32'h0, "tf_hi");
        wait_cyc(h + 5);
        bus_read(0, CLINT_MTIME_HI, 32'h0, "tf_hi_snapshot");
        bus_read(0, CLINT_MTIME_LO, 32'h4, "tf_lo_wrapped");
        bus_read(0, CLINT_MTIME_HI, 32'h1, "tf_hi_live");

        // Full 64-bit wrap.
        bus_write(CLINT_MTIME_HI, 32'hFFFF_FFFF, 4'hF);
        bus_write(CLINT_MTIME_LO, 32'hFFFF_FFFF, 4'hF);
        l = cyc;
        bus_read(0, CLINT_MTIME_LO, 32'hFFFF_FFFF, "wrap_pre_lo");
        bus_read(0, CLINT_MTIME_LO, 32'h0, "wrap_lo");
        bus_read(0, CLINT_MTIME_HI, 32'h0, "wrap_hi");

        // Partial-strobe write on a tick cycle: merge, no increment.
        bus_write(CLINT_MTIME_LO, 32'hAABB_0000, 4'hF);
        bus_write(CLINT_MTIME_LO, 32'h1234_5678, 4'b0011);
        bus_read(0, CLINT_MTIME_LO, 32'hAABB_5678, "collide_lo");
        bus_read(0, CLINT_MTIME_HI, 32'h0, "collide_hi");
        bus_write(16'h4000, 32'h1122_3344, 4'b0101);
        bus_read(0, 16'h4000, 32'hFF22_FF44, "cmp0_strb");

        // Software interrupt and unmapped accesses.
        bus_write(16'h0004, 32'hFFFF_FFFF, 4'hF);
        check("msip_lag", 64'(msip_a), 64'b00);
        @(negedge CLK);
        check("msip_set", 64'(msip_a), 64'b10);
        bus_read(0, 16'h0004, 32'h1, "msip1_rd");
        bus_read(0, 16'h0000, 32'h0, "msip0_rd");
        bus_write(16'h0000, 32'h1, 4'b1110);
        bus_write(16'h0002, 32'hFFFF_FFFF, 4'hF);
        bus_write(16'h0008, 32'hFFFF_FFFF, 4'hF);
        bus_write(16'h4010, 32'hFFFF_FFFF, 4'hF);
        bus_read(0, 16'h0002, 32'h0, "unmap_misaligned");
        bus_read(0, 16'h0008, 32'h0, "unmap_msip2");
        bus_read(0, 16'h4010, 32'h0, "unmap_cmp2");
        bus_read(0, 16'h0000, 32'h0, "msip0_after");
        check("msip_final", 64'(msip_a), 64'b10);
        bus_read(0, 16'h0004, 32'h1, "msip1_final");

        repeat (3) @(negedge CLK);
        check("rdata_hold", 64'(rdata_a), 64'h1);
        repeat (2) @(negedge CLK);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
